// File: rtl/ascon_params.sv
// rtl/ascon_params.sv - shared Ascon datapath widths and deserializer state encoding
package ascon_params;

  localparam int WORD_SIZE    = 64;
  localparam int SHIFT_WIDTH  = 5;
  localparam int NUM_SLICES   = (WORD_SIZE + SHIFT_WIDTH - 1) / SHIFT_WIDTH;
  localparam int PADDED_WIDTH = NUM_SLICES * SHIFT_WIDTH;
  // Keep the counter at least one bit wide so a single-slice build still elaborates.
  localparam int CNT_WIDTH    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic {
    DESER_COLLECT = 1'b0,
    DESER_FULL    = 1'b1
  } deser_state_t;

endpackage

// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - reassembles SHIFT_WIDTH slices (LSB first) into one WORD_SIZE word
// Optional pad-bit error flag under `define PAD_CHECK_EN.
module shift_deserializer #(
  parameter int WORD_SIZE   = ascon_params::WORD_SIZE,
  parameter int SHIFT_WIDTH = ascon_params::SHIFT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SHIFT_WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_SIZE-1:0]   out_data,
  output logic                   busy
`ifdef PAD_CHECK_EN
  ,
  output logic                   pad_err
`endif
);

  import ascon_params::deser_state_t;
  import ascon_params::DESER_COLLECT;
  import ascon_params::DESER_FULL;

  localparam int NUM_SLICES   = (WORD_SIZE + SHIFT_WIDTH - 1) / SHIFT_WIDTH;
  localparam int PADDED_WIDTH = NUM_SLICES * SHIFT_WIDTH;
  localparam int CNT_WIDTH    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam bit SINGLE_SLICE = (NUM_SLICES == 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_SLICES - 1);

  deser_state_t            state;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [PADDED_WIDTH-1:0] sreg;
  logic [PADDED_WIDTH-1:0] sreg_shift;

  logic accept;
  logic deliver;
  logic word_done;

  generate
    if (SINGLE_SLICE) begin : g_one_slice
      assign sreg_shift = in_data;
    end else begin : g_multi_slice
      assign sreg_shift = {in_data, sreg[PADDED_WIDTH-1:SHIFT_WIDTH]};
    end
  endgenerate

  // In FULL the input side only opens when the word is leaving this cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!clear) begin
      in_ready  = (state == DESER_COLLECT) ? 1'b1 : out_ready;
      out_valid = (state == DESER_FULL);
    end
  end

  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid & out_ready;
  assign out_data = sreg[WORD_SIZE-1:0];
  assign busy     = (state == DESER_COLLECT) && (cnt != '0);

  // A word completes either on its last slice in COLLECT, or on reload in a one-slice build.
  assign word_done = accept &&
                     (((state == DESER_COLLECT) && (cnt == LAST_CNT)) ||
                      ((state == DESER_FULL) && SINGLE_SLICE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= DESER_COLLECT;
      cnt   <= '0;
      sreg  <= '0;
    end else if (clear) begin
      state <= DESER_COLLECT;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      if (accept) begin
        sreg <= sreg_shift;
      end
      case (state)
        DESER_COLLECT: begin
          if (accept) begin
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              state <= DESER_FULL;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        DESER_FULL: begin
          if (deliver) begin
            if (accept && SINGLE_SLICE) begin
              cnt   <= '0;
              state <= DESER_FULL;
            end else if (accept) begin
              cnt   <= CNT_WIDTH'(1);
              state <= DESER_COLLECT;
            end else begin
              cnt   <= '0;
              state <= DESER_COLLECT;
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= DESER_COLLECT;
        end
      endcase
    end
  end

`ifdef PAD_CHECK_EN
  logic pad_bad;

  generate
    if (PADDED_WIDTH > WORD_SIZE) begin : g_pad_bits
      assign pad_bad = |sreg_shift[PADDED_WIDTH-1:WORD_SIZE];
    end else begin : g_no_pad
      assign pad_bad = 1'b0;
    end
  endgenerate

  // Flag is loaded on the same edge that raises out_valid and lives until the word leaves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_err <= 1'b0;
    end else if (clear) begin
      pad_err <= 1'b0;
    end else if (word_done) begin
      pad_err <= pad_bad;
    end else if (deliver) begin
      pad_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// tb/tb_shift_deserializer.sv - directed and randomized checks for shift_deserializer
module tb_shift_deserializer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_data = 5'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;
`ifdef PAD_CHECK_EN
  logic        pad_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_deserializer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef PAD_CHECK_EN
    ,
    .pad_err   (pad_err)
`endif
  );

  function automatic logic [4:0] slice_of(input logic [63:0] w, input int i);
    logic [64:0] p;
    p = {1'b0, w};
    return p[5*i +: 5];
  endfunction

  // Presents one slice and returns #1 after the edge that accepted it; in_valid stays high.
  task automatic send_slice(input logic [4:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_slice_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_word();
    logic [63:0] w;
    w = 64'h0123_4567_89AB_CDEF;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send_slice(slice_of(w, i));
      if (i < 12) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy slice %0d got %0b want 1", i, busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid slice %0d got %0b want 0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %0b want 1", out_valid); end
    checks++; if (out_data !== w) begin errors++; $display("FAIL single_out_data got %h want %h", out_data, w); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_full got %0b want 0", busy); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w1;
    logic [63:0] w2;
    w1 = 64'h1122_3344_5566_7788;
    w2 = 64'hFFFF_0000_AAAA_5555;
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) send_slice(slice_of(w1, i));
    in_data = slice_of(w2, 0);
    checks++; if (out_data !== w1) begin errors++; $display("FAIL b2b_first_data got %h want %h", out_data, w1); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready cycle %0d got %0b want 0", c, in_ready); end
      checks++; if (out_data !== w1 || out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_stall_hold cycle %0d got %h/%0b want %h/1", c, out_data, out_valid, w1);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_pass_ready got %0b want 1", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_after_deliver got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_slice0_taken got %0b want 1", busy); end
    for (int i = 1; i < 13; i++) send_slice(slice_of(w2, i));
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %0b want 1", out_valid); end
    checks++; if (out_data !== w2) begin errors++; $display("FAIL b2b_second_data got %h want %h", out_data, w2); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [63:0] exp_q[$];
    int received;
    received = 0;
    fork
      begin
        for (int n = 0; n < 100; n++) begin
          logic [63:0] w;
          w = {$urandom, $urandom};
          exp_q.push_back(w);
          for (int i = 0; i < 13; i++) begin
            while ($urandom_range(0, 9) < 3) begin
              in_valid = 1'b0;
              @(posedge clk);
              #1;
            end
            send_slice(slice_of(w, i));
          end
          in_valid = 1'b0;
        end
      end
      begin
        int cyc;
        logic [63:0] e;
        cyc = 0;
        while (received < 100 && cyc < 20000) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 9) < 8);
          @(negedge clk);
          if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL random_extra_word got %h want none", out_data);
            end else begin
              e = exp_q.pop_front();
              if (out_data !== e) begin errors++; $display("FAIL random_word %0d got %h want %h", received, out_data, e); end
            end
            received++;
          end
          cyc++;
        end
      end
    join
    checks++; if (received != 100) begin errors++; $display("FAIL random_count got %0d want 100", received); end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_clear();
    logic [63:0] w;
    w = 64'hDEAD_BEEF_CAFE_F00D;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_slice(slice_of(64'hAAAA_AAAA_AAAA_AAAA, i));
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy_before got %0b want 1", busy); end
    in_data = 5'h1F;
    clear = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready got %0b want 0", in_ready); end
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy_after got %0b want 0", busy); end
    for (int i = 0; i < 13; i++) send_slice(slice_of(w, i));
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clear_fresh_valid got %0b want 1", out_valid); end
    checks++; if (out_data !== w) begin errors++; $display("FAIL clear_fresh_data got %h want %h", out_data, w); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    logic [63:0] w;
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) send_slice(slice_of(64'h1357_9BDF_2468_ACE0, i));
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_full got %0b want 1", out_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL areset_out_data got %h want 0", out_data); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    w = 64'h0F1E_2D3C_4B5A_6978;
    for (int i = 0; i < 13; i++) send_slice(slice_of(w, i));
    in_valid = 1'b0;
    checks++; if (out_data !== w || out_valid !== 1'b1) begin
      errors++; $display("FAIL areset_next_word got %h/%0b want %h/1", out_data, out_valid, w);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef PAD_CHECK_EN
  task automatic test_pad();
    logic [63:0] w;
    w = 64'h0FED_CBA9_8765_4321;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) send_slice(slice_of(w, i));
    send_slice(5'b1_0000);
    in_valid = 1'b0;
    checks++; if (pad_err !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL pad_err_set got %0b/%0b want 1/1", pad_err, out_valid);
    end
    checks++; if (out_data !== w) begin errors++; $display("FAIL pad_data got %h want %h", out_data, w); end
    @(posedge clk);
    #1;
    checks++; if (pad_err !== 1'b0) begin errors++; $display("FAIL pad_err_clear got %0b want 0", pad_err); end
    for (int i = 0; i < 12; i++) send_slice(slice_of(w, i));
    send_slice(5'b0_1111);
    in_valid = 1'b0;
    checks++; if (pad_err !== 1'b0) begin errors++; $display("FAIL pad_err_clean got %0b want 0", pad_err); end
    checks++; if (out_data !== 64'hFFED_CBA9_8765_4321) begin
      errors++; $display("FAIL pad_clean_data got %h want ffedcba987654321", out_data);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_random();
    test_clear();
    test_async_reset();
`ifdef PAD_CHECK_EN
    test_pad();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Receive-side counterpart of the word serializer.
- Accepts SHIFT_WIDTH-bit slices, LSB slice first, and reassembles one WORD_SIZE-bit word.
- Strips the zero padding the transmitter adds above bit WORD_SIZE-1.
- Sits between the narrow datapath of the Ascon core and the word-wide state/output interface. Uses valid/ready on both sides.

Parameters:
- WORD_SIZE, 64, width of the reassembled word (ascon_params::WORD_SIZE).
- SHIFT_WIDTH, 5, slice width per transfer (ascon_params::SHIFT_WIDTH); legal range 1..WORD_SIZE.
- NUM_SLICES, ceil(WORD_SIZE/SHIFT_WIDTH) = 13, derived local constant; not overridable.
- PADDED_WIDTH, NUM_SLICES*SHIFT_WIDTH = 65, derived local constant (ascon_params::PADDED_WIDTH).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; drops the partial word and any held word.
- in_valid  in  1  slice valid.
- in_ready  out  1  slice accepted when in_valid & in_ready.
- in_data  in  SHIFT_WIDTH  slice; first slice = word bits [SHIFT_WIDTH-1:0].
- out_valid  out  1  out_data holds a complete word.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- out_data  out  WORD_SIZE  reassembled word.
- busy  out  1  at least one slice of the current word has been accepted and the word is not yet complete.

Behaviour:
- Storage: PADDED_WIDTH-bit register sreg, slice counter cnt (clog2(NUM_SLICES) bits), state in {COLLECT, FULL}.
- Reset (async): sreg=0, cnt=0, state=COLLECT. Outputs: out_valid=0, busy=0, out_data=0, in_ready=1 once reset releases.
- Slice accept: on in_valid & in_ready, sreg <= {in_data, sreg[PADDED_WIDTH-1:SHIFT_WIDTH]} (right shift, insert at top). After NUM_SLICES accepts, slice 0 lies at sreg[SHIFT_WIDTH-1:0].
- out_data = sreg[WORD_SIZE-1:0]. Pad bits sreg[PADDED_WIDTH-1:WORD_SIZE] are discarded.
- COLLECT:
  - in_ready=1, out_valid=0.
  - Each accept increments cnt.
  - Accept with cnt==NUM_SLICES-1: cnt<=0, state<=FULL.
  - out_valid rises the cycle after the last slice is accepted (latency 1 from the final accept).
- FULL:
  - out_valid=1; out_data held stable until the handshake completes.
  - in_ready = out_ready, which allows pass-through throughput.
  - out_valid & out_ready without an input accept: state<=COLLECT.
  - out_valid & out_ready with a simultaneous input accept: the word is delivered, the slice is shifted in as slice 0 of the next word, cnt<=1, state<=COLLECT. If NUM_SLICES==1, state stays FULL.
  - Sustained rate is one word per NUM_SLICES cycles with no bubble.
- busy = (state==COLLECT) & (cnt!=0).
- clear: highest priority after reset. cnt<=0, state<=COLLECT, sreg<=0. Any simultaneous slice or output handshake is ignored: in_ready and out_valid are forced 0 combinationally while clear=1.
- Input contract: in_data must be stable while in_valid=1 and in_ready=0. The block must not drop out_valid without a handshake.

Optional Feature:
- Macro PAD_CHECK_EN.
- Defined:
  - Adds output pad_err (1 bit, reset 0).
  - pad_err is set in the same cycle out_valid rises if any discarded pad bit sreg[PADDED_WIDTH-1:WORD_SIZE] is nonzero.
  - pad_err is valid while out_valid=1 and clears with the output handshake or clear.
  - When PADDED_WIDTH==WORD_SIZE, pad_err is tied 0.
- Not defined: port absent; pad bits are silently discarded.

Decomposition:
- ascon_params supplies WORD_SIZE, SHIFT_WIDTH, PADDED_WIDTH.
- Add to ascon_params:
  - NUM_SLICES and CNT_WIDTH constants.
  - typedef enum logic {DESER_COLLECT, DESER_FULL} deser_state_t.
- Single module; no sub-module. The counter and shift register are too small to split.

Test Plan:
- Word 64'h0123_4567_89AB_CDEF sent as 13 slices (slice i = word[5i+4:5i], top slice bit4=0), in_valid held high, out_ready=1 -> out_valid high exactly 1 cycle after the 13th accept; out_data=64'h0123_4567_89AB_CDEF; busy high for slices 1..12.
- Two words back-to-back, out_ready=0 for 5 cycles after the first completes -> in_ready=0 and out_data stable during the stall. After out_ready=1, the first word is delivered and slice 0 of the second is accepted in the same cycle. Second word 64'hFFFF_0000_AAAA_5555 is correct.
- Random in_valid gaps (~30% idle) over 100 random words -> every out_data matches the scoreboard; no lost or duplicated slices.
- clear asserted after 6 slices, then a fresh 13-slice word 64'hDEAD_BEEF_CAFE_F00D -> busy drops next cycle; output equals the fresh word only.
- reset_n pulsed low for 1 cycle while in FULL -> out_valid=0 and out_data=0 immediately (async); the next 13 slices give a correct word.
- PAD_CHECK_EN defined, top slice = 5'b1_0000 -> pad_err=1 alongside out_valid, with out_data bits [63:60]=0. Top slice 5'b0_1111 -> pad_err=0.
